// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage and the ALU.
// Contents:
//   - 4-bit ALU operation codes
//   - main-decoder alu_op classes
//   - R-type funct field values
//   - forwarding-source select helper
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_EQ  = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_EQ    = 2'b11
    } alu_class_t;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Operand forwarding. The nearer stage (EX/MEM) has priority.
    // Register 0 is hard-wired to zero, so it is never forwarded.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  addr,
        input logic        exmem_we,
        input logic [4:0]  exmem_rd,
        input logic [31:0] exmem_val,
        input logic        memwb_we,
        input logic [4:0]  memwb_rd,
        input logic [31:0] memwb_val,
        input logic [31:0] rf_val
    );
        if (exmem_we && exmem_rd == addr && addr != 5'd0)
            return exmem_val;
        else if (memwb_we && memwb_rd == addr && addr != 5'd0)
            return memwb_val;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU control decoder.
// Maps the main-decoder class and the R-type funct field to the 4-bit ALU
// operation code.
// Ports:
//   alu_op    - main-decoder class
//   funct     - R-type function field
//   operation - ALU operation code
//   illegal   - R-type funct not recognised (operation reads as AND)
module alu_control
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    always_comb begin
        operation = ALU_AND;
        illegal   = 1'b0;
        case (alu_class_t'(alu_op))
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_EQ:  operation = ALU_EQ;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_AND: operation = ALU_AND;
                    FUNCT_OR:  operation = ALU_OR;
                    FUNCT_ADD: operation = ALU_ADD;
                    FUNCT_SUB: operation = ALU_SUB;
                    FUNCT_SLT: operation = ALU_SLT;
                    default:   illegal   = 1'b1;
                endcase
            end
            default: operation = ALU_AND;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand select in front of the 32-bit ALU.
// This is a single-entry register with a valid/ready handshake.
// Operands are forwarded from EX/MEM and MEM/WB at capture time only.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   in_valid/in_ready              - upstream handshake
//   rs_*, rt_*, imm                - decoded source fields
//   alu_src, alu_op, funct         - decoded control fields
//   dest_addr, reg_write           - decoded writeback fields
//   exmem_*, memwb_*               - forwarding sources
//   flush                          - kill held and incoming instruction
//   out_valid/out_ready            - downstream handshake
//   out_*                          - registered fields for the ALU
//   stall_count                    - saturating back-pressure cycle count
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  dest_addr,
    input  logic        reg_write,
    input  logic        exmem_reg_write,
    input  logic        memwb_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_operation,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_dest,
    output logic        out_reg_write,
    output logic        out_illegal,
    output logic [15:0] stall_count
);

    logic [4:0]  src_addr [2];
    logic [31:0] src_data [2];
    logic [31:0] fwd_data [2];

    assign src_addr[0] = rs_addr;
    assign src_addr[1] = rt_addr;
    assign src_data[0] = rs_data;
    assign src_data[1] = rt_data;

    // Index 0 is rs and index 1 is rt. Both use the same forwarding rule.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_data[gi] = fwd_select(src_addr[gi],
                                         exmem_reg_write, exmem_rd, exmem_result,
                                         memwb_reg_write, memwb_rd, memwb_result,
                                         src_data[gi]);
    end

    logic [3:0] operation_next;
    logic       illegal_next;

    alu_control u_alu_control (
        .alu_op    (alu_op),
        .funct     (funct),
        .operation (operation_next),
        .illegal   (illegal_next)
    );

    logic [31:0] b_next;
    assign b_next = alu_src ? {{16{imm[15]}}, imm} : fwd_data[1];

    logic        valid_reg;
    logic [31:0] a_reg, b_reg, store_reg;
    logic [3:0]  operation_reg;
    logic [4:0]  dest_reg;
    logic        reg_write_reg, illegal_reg;
    logic [15:0] stall_reg;
    logic        capture;

    assign in_ready = !valid_reg || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            store_reg     <= '0;
            operation_reg <= ALU_AND;
            dest_reg      <= '0;
            reg_write_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            stall_reg     <= '0;
        end else begin
            // Flush beats capture and drain. A capture while draining
            // replaces the held entry and keeps valid high.
            if (flush)
                valid_reg <= 1'b0;
            else if (capture)
                valid_reg <= 1'b1;
            else if (valid_reg && out_ready)
                valid_reg <= 1'b0;

            if (capture) begin
                a_reg         <= fwd_data[0];
                b_reg         <= b_next;
                store_reg     <= fwd_data[1];
                operation_reg <= operation_next;
                dest_reg      <= dest_addr;
                reg_write_reg <= reg_write && !illegal_next;
                illegal_reg   <= illegal_next;
            end

            if (valid_reg && !out_ready && stall_reg != 16'hFFFF)
                stall_reg <= stall_reg + 16'd1;
        end
    end

    assign out_valid      = valid_reg;
    assign out_a          = a_reg;
    assign out_b          = b_reg;
    assign out_store_data = store_reg;
    assign out_operation  = operation_reg;
    assign out_dest       = dest_reg;
    assign out_reg_write  = reg_write_reg;
    assign out_illegal    = illegal_reg;
    assign stall_count    = stall_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  dest_addr;
    logic        reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_store_data;
    logic [3:0]  out_operation;
    logic [4:0]  out_dest;
    logic        out_reg_write, out_illegal;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .imm             (imm),
        .alu_src         (alu_src),
        .alu_op          (alu_op),
        .funct           (funct),
        .dest_addr       (dest_addr),
        .reg_write       (reg_write),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_a           (out_a),
        .out_b           (out_b),
        .out_operation   (out_operation),
        .out_store_data  (out_store_data),
        .out_dest        (out_dest),
        .out_reg_write   (out_reg_write),
        .out_illegal     (out_illegal),
        .stall_count     (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"},  {31'd0, out_valid},      32'd0);
        chk({tag, ".a"},      out_a,                   32'd0);
        chk({tag, ".b"},      out_b,                   32'd0);
        chk({tag, ".store"},  out_store_data,          32'd0);
        chk({tag, ".op"},     {28'd0, out_operation},  32'd0);
        chk({tag, ".dest"},   {27'd0, out_dest},       32'd0);
        chk({tag, ".rw"},     {31'd0, out_reg_write},  32'd0);
        chk({tag, ".ill"},    {31'd0, out_illegal},    32'd0);
        chk({tag, ".stall"},  {16'd0, stall_count},    32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
        imm = 0; alu_src = 0; alu_op = 2'b00; funct = 0; dest_addr = 0; reg_write = 0;
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0; flush = 0; out_ready = 1;

        tick();
        chk_reset_state("reset");
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // R-type add: 5 + 7
        in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 5; rt_data = 7;
        alu_op = 2'b10; funct = 6'b100000; dest_addr = 4; reg_write = 1;
        tick();
        chk("add.valid", {31'd0, out_valid}, 32'd1);
        chk("add.a", out_a, 32'd5);
        chk("add.b", out_b, 32'd7);
        chk("add.op", {28'd0, out_operation}, 32'h2);
        chk("add.dest", {27'd0, out_dest}, 32'd4);
        chk("add.rw", {31'd0, out_reg_write}, 32'd1);
        chk("add.ill", {31'd0, out_illegal}, 32'd0);

        // Immediate: B is sign-extended imm, store data is still rt
        alu_src = 1; imm = 16'hFFFE; alu_op = 2'b00;
        tick();
        chk("imm.valid", {31'd0, out_valid}, 32'd1);
        chk("imm.b", out_b, 32'hFFFF_FFFE);
        chk("imm.op", {28'd0, out_operation}, 32'h2);
        chk("imm.store", out_store_data, 32'd7);

        // Forwarding: EX/MEM beats MEM/WB, for both rs and rt
        alu_src = 0; alu_op = 2'b01; rs_addr = 3; rt_addr = 3; rs_data = 32'h11; rt_data = 32'h22;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        tick();
        chk("fwd_ex.a", out_a, 32'hAA);
        chk("fwd_ex.b", out_b, 32'hAA);
        chk("fwd_ex.store", out_store_data, 32'hAA);
        chk("fwd_ex.op", {28'd0, out_operation}, 32'h3);

        // EX/MEM does not match, so MEM/WB supplies the value
        exmem_rd = 6;
        tick();
        chk("fwd_wb.a", out_a, 32'hBB);

        // Register 0 is never forwarded
        rs_addr = 0; rt_addr = 0; rs_data = 32'h123; rt_data = 32'h456; exmem_rd = 0; memwb_rd = 0;
        tick();
        chk("fwd_r0.a", out_a, 32'h123);
        chk("fwd_r0.b", out_b, 32'h456);
        exmem_reg_write = 0; memwb_reg_write = 0;

        // Back-pressure. Capture X with out_ready still high.
        rs_addr = 1; rt_addr = 2; rs_data = 32'h55; rt_data = 32'h66; alu_op = 2'b11;
        tick();
        chk("bp.cap.a", out_a, 32'h55);
        chk("bp.cap.op", {28'd0, out_operation}, 32'h6);
        out_ready = 0; rs_data = 32'h77; alu_op = 2'b01;
        #1;
        chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("bp.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.hold.a", out_a, 32'h55);
        chk("bp.hold.op", {28'd0, out_operation}, 32'h6);
        chk("bp.stall", {16'd0, stall_count}, 32'd4);
        chk("bp.in_ready2", {31'd0, in_ready}, 32'd0);

        // Drain and capture together: Y replaces X
        out_ready = 1;
        tick();
        chk("rep.valid", {31'd0, out_valid}, 32'd1);
        chk("rep.a", out_a, 32'h77);
        chk("rep.op", {28'd0, out_operation}, 32'h3);
        chk("rep.stall", {16'd0, stall_count}, 32'd4);

        // Illegal funct
        alu_op = 2'b10; funct = 6'b111111; reg_write = 1;
        tick();
        chk("ill.ill", {31'd0, out_illegal}, 32'd1);
        chk("ill.rw", {31'd0, out_reg_write}, 32'd0);
        chk("ill.op", {28'd0, out_operation}, 32'h0);

        // Flush blocks the incoming instruction
        flush = 1; funct = 6'b100101; rs_data = 32'h99;
        tick();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.a_held", out_a, 32'h77);
        flush = 0;

        // OR, then SLT, then drain with no new input
        tick();
        chk("or.op", {28'd0, out_operation}, 32'h1);
        chk("or.a", out_a, 32'h99);
        funct = 6'b101010;
        tick();
        chk("slt.op", {28'd0, out_operation}, 32'h7);
        in_valid = 0;
        tick();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);
        chk("drain.op_held", {28'd0, out_operation}, 32'h7);

        // Asynchronous reset mid-stall
        in_valid = 1; funct = 6'b100010; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
        chk("stall2.stall", {16'd0, stall_count}, 32'd5);
        chk("stall2.valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1;
        #1;
        chk_reset_state("async_rst");
        #1;
        rst = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-select stage directly upstream of the 32-bit ALU. Captures decoded instruction fields from the decode stage, resolves operand forwarding from the EX/MEM and MEM/WB stages, and decodes the 4-bit ALU operation code. It presents registered A, B and operation to the ALU under a valid/ready handshake, with stall and flush support.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register addresses).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode stage offers an instruction
- in_ready  out  1  stage can accept this cycle
- rs_addr, rt_addr  in  5  source register numbers
- rs_data, rt_data  in  32  register-file read data
- imm  in  16  instruction immediate
- alu_src  in  1  1: B = sign-extended imm; 0: B = forwarded rt
- alu_op  in  2  main-decoder class: 00 add, 01 sub, 10 R-type (use funct), 11 equality
- funct  in  6  R-type function field
- dest_addr  in  5  writeback register
- reg_write  in  1  instruction writes a register
- exmem_reg_write, memwb_reg_write  in  1  forwarding-source write enables
- exmem_rd, memwb_rd  in  5  forwarding-source destinations
- exmem_result, memwb_result  in  32  forwarding-source values
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  registered instruction valid for ALU
- out_ready  in  1  downstream accepts
- out_a, out_b  out  32  ALU operands
- out_operation  out  4  ALU operation code
- out_store_data  out  32  forwarded rt value, for stores
- out_dest  out  5; out_reg_write  out  1
- out_illegal  out  1  R-type funct not recognised
- stall_count  out  16  saturating count of back-pressure cycles

## Operation
- in_ready = !out_valid || out_ready (combinational, single-entry register).
- Capture on in_valid && in_ready && !flush: all out_* registers load; out_valid ← 1.
- out_valid && out_ready with no capture: out_valid ← 0; data registers hold.
- Forwarding, evaluated at capture, per source (rs, rt): EX/MEM wins if exmem_reg_write && exmem_rd == addr && addr != 0; else MEM/WB under the same rule; else register-file data. Register 0 is never forwarded.
- out_a = forwarded rs. out_store_data = forwarded rt. out_b = alu_src ? {{16{imm[15]}}, imm} : forwarded rt.
- Operation decode: alu_op 00 → 0010; 01 → 0011; 11 → 0110; 10 with funct 100100 → 0000 (and), 100101 → 0001 (or), 100000 → 0010 (add), 100010 → 0011 (sub), 101010 → 0111 (slt). Any other funct gives 0000 with out_illegal = 1 and out_reg_write forced to 0.
- flush: out_valid ← 0 next edge; no capture that cycle regardless of in_valid. Flush overrides both capture and drain.
- stall_count increments each cycle out_valid && !out_ready; saturates at 0xFFFF; cleared only by reset.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Back-pressure: while out_valid && !out_ready, all out_* are stable and in_ready = 0.
- Simultaneous drain and capture in the same cycle: the new instruction replaces the old one; out_valid stays 1.
- Reset (asynchronous, any time including mid-stall): out_valid 0, out_a/out_b/out_store_data 0, out_operation 0000, out_dest 0, out_reg_write 0, out_illegal 0, stall_count 0.
- Forwarding inputs are sampled only on the capture edge; held entries are not re-forwarded.

## Structure
- Shared package: the 4-bit ALU op-code constants (AND 0000, OR 0001, ADD 0010, SUB 0011, EQ 0110, SLT 0111), the alu_op class encodings, and the R-type funct constants. The ALU and this stage both use them.
- One sub-module, alu_control: combinational (alu_op, funct) → (operation, illegal). The forwarding muxes and registers stay in id_ex_stage.

## Test plan
- Plain R-type add: rs_data 5, rt_data 7, alu_op 10, funct 100000, out_ready 1 → next cycle out_valid 1, out_a 5, out_b 7, out_operation 0010.
- Immediate sign extension: alu_src 1, imm 0xFFFE, alu_op 00 → out_b 0xFFFFFFFE, out_operation 0010.
- Forwarding priority: rs_addr 3, exmem_rd 3 with value 0xAA, memwb_rd 3 with value 0xBB, both write enables 1 → out_a 0xAA. Repeat with rs_addr 0 → out_a = rs_data.
- Back-pressure: out_ready 0 for 4 cycles after capture → in_ready 0, outputs stable, stall_count 4. Then out_ready and in_valid both 1 → next instruction replaces the held one in the same cycle.
- Flush plus illegal funct: funct 111111 → out_illegal 1, out_reg_write 0, out_operation 0000. Assert flush with in_valid 1 → out_valid 0 next cycle.
- Asynchronous reset asserted mid-stall, between clock edges → all outputs at their reset values immediately, before the next edge.
